riscv_divider: RTL

- Multi-cycle RV64M divide/remainder responder for the execute stage.
- Accepts operands plus the 3-bit divide control issued alongside the ALU.
- Runs a restoring shift-subtract iteration and returns the result with a one-cycle valid pulse.
- Holds a busy/stall line to the hazard unit while iterating. Covers DIV/DIVU/REM/REMU and the W forms.

---
 rtl/riscv_div_pkg.sv | 29 ++
 rtl/riscv_div_step.sv | 27 ++
 rtl/riscv_divider.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_div_pkg.sv
// Shared types and constants for the RV64M divider.
// Optional feature macro: RISCV_DIV_RADIX4_EN (two restoring steps per cycle).
package riscv_div_pkg;

   // Divider sequencing states
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } div_state_e;

   // Divide control encodings; bit 2 is the request, 3'b0xx means no request
   localparam logic [2:0] DivctrlNone = 3'b000;
   localparam logic [2:0] DivctrlDiv  = 3'b100;
   localparam logic [2:0] DivctrlDivu = 3'b101;
   localparam logic [2:0] DivctrlRem  = 3'b110;
   localparam logic [2:0] DivctrlRemu = 3'b111;

   // Restoring steps retired per BUSY cycle
   localparam int unsigned StepsR2 = 1;
   localparam int unsigned StepsR4 = 2;

   // Iteration counts (BUSY cycles) for the 64-bit and 32-bit word forms
   localparam int unsigned IterR2Dword = 64;
   localparam int unsigned IterR2Word  = 32;
   localparam int unsigned IterR4Dword = 32;
   localparam int unsigned IterR4Word  = 16;

endpackage

// File: rtl/riscv_div_step.sv
// One combinational restoring divide step: shift {rem, quo} left by one,
// trial-subtract the divisor, keep the difference if non-negative and shift
// the resulting quotient bit into the quotient LSB.
module riscv_div_step #(
   parameter int unsigned width = 64
) (
   input  logic [width-1:0] rem_i,
   input  logic [width-1:0] quo_i,
   input  logic [width-1:0] dvsr_i,
   output logic [width-1:0] rem_o,
   output logic [width-1:0] quo_o
);

   logic [width:0]   shifted;
   logic [width+1:0] diff;
   logic             neg;

   // Trial subtraction; remainder stays below the divisor so width bits suffice
   always_comb begin
      shifted = {rem_i, quo_i[width-1]};
      diff    = {1'b0, shifted} - {2'b00, dvsr_i};
      neg     = diff[width+1];
      rem_o   = neg ? shifted[width-1:0] : diff[width-1:0];
      quo_o   = {quo_i[width-2:0], ~neg};
   end

endmodule

// File: rtl/riscv_divider.sv
// Multi-cycle RV64M DIV/DIVU/REM/REMU (+W forms) unit for the execute stage.
// Restoring shift-subtract on operand magnitudes, signs fixed up at the end.
// Optional feature macro: RISCV_DIV_RADIX4_EN chains two steps per cycle.
module riscv_divider
   import riscv_div_pkg::*;
#(
   parameter int unsigned width = 64
) (
   input  logic             i_riscv_div_clk,
   input  logic             i_riscv_div_rst,
   input  logic [2:0]       i_riscv_div_divctrl,
   input  logic             i_riscv_div_word,
   input  logic [width-1:0] i_riscv_div_rs1data,
   input  logic [width-1:0] i_riscv_div_rs2data,
   input  logic             i_riscv_div_kill,
   output logic [width-1:0] o_riscv_div_result,
   output logic             o_riscv_div_valid,
   output logic             o_riscv_div_busy
);

`ifdef RISCV_DIV_RADIX4_EN
   localparam int unsigned StepsPerCycle = StepsR4;
   localparam int unsigned IterWord      = IterR4Word;
`else
   localparam int unsigned StepsPerCycle = StepsR2;
   localparam int unsigned IterWord      = IterR2Word;
`endif
   localparam int unsigned IterFull = width / StepsPerCycle;
   localparam int unsigned CntW     = $clog2(width + 1);

   // Sign-extend the low 32 bits of a value to the full width
   function automatic logic [width-1:0] wext(input logic [width-1:0] v);
      return {{(width-32){v[31]}}, v[31:0]};
   endfunction

   div_state_e       state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [width-1:0] acc_q, acc_d;     // partial remainder
   logic [width-1:0] quo_q, quo_d;     // dividend shifting out, quotient shifting in
   logic [width-1:0] dvsr_q, dvsr_d;
   logic [width-1:0] result_q, result_d;
   logic             is_rem_q, is_rem_d;
   logic             word_q, word_d;
   logic             neg_q_q, neg_q_d;
   logic             neg_r_q, neg_r_d;

   logic [width-1:0] step_rem, step_quo;

   // Accept-time decode
   logic             req, is_signed, is_rem;
   logic [width-1:0] op_a, op_b, mag_a, mag_b, min_val, spec_res;
   logic             a_neg, b_neg, div_zero, ovf;

   // Completion fix-up
   logic [width-1:0] q_fin, r_fin, res_fin;

   // Operand extension, magnitudes and special-case detection
   always_comb begin
      req       = i_riscv_div_divctrl[2];
      is_signed = (i_riscv_div_divctrl == DivctrlDiv) || (i_riscv_div_divctrl == DivctrlRem);
      is_rem    = (i_riscv_div_divctrl == DivctrlRem) || (i_riscv_div_divctrl == DivctrlRemu);
      if (i_riscv_div_word) begin
         op_a = is_signed ? wext(i_riscv_div_rs1data)
                          : {{(width-32){1'b0}}, i_riscv_div_rs1data[31:0]};
         op_b = is_signed ? wext(i_riscv_div_rs2data)
                          : {{(width-32){1'b0}}, i_riscv_div_rs2data[31:0]};
         min_val = {{(width-31){1'b1}}, 31'b0};
      end else begin
         op_a    = i_riscv_div_rs1data;
         op_b    = i_riscv_div_rs2data;
         min_val = {1'b1, {(width-1){1'b0}}};
      end
      // Word signed operands are already sign-extended, so the top bit is the sign
      a_neg    = is_signed & op_a[width-1];
      b_neg    = is_signed & op_b[width-1];
      mag_a    = a_neg ? -op_a : op_a;
      mag_b    = b_neg ? -op_b : op_b;
      div_zero = (op_b == '0);
      ovf      = is_signed && (op_a == min_val) && (op_b == '1);
      if (div_zero) begin
         spec_res = is_rem ? op_a : '1;
      end else begin
         spec_res = is_rem ? '0 : op_a;
      end
      if (i_riscv_div_word) begin
         spec_res = wext(spec_res);
      end
   end

`ifdef RISCV_DIV_RADIX4_EN
   logic [width-1:0] mid_rem, mid_quo;

   riscv_div_step #(.width(width)) u_step0 (
      .rem_i  (acc_q),
      .quo_i  (quo_q),
      .dvsr_i (dvsr_q),
      .rem_o  (mid_rem),
      .quo_o  (mid_quo)
   );

   riscv_div_step #(.width(width)) u_step1 (
      .rem_i  (mid_rem),
      .quo_i  (mid_quo),
      .dvsr_i (dvsr_q),
      .rem_o  (step_rem),
      .quo_o  (step_quo)
   );
`else
   riscv_div_step #(.width(width)) u_step0 (
      .rem_i  (acc_q),
      .quo_i  (quo_q),
      .dvsr_i (dvsr_q),
      .rem_o  (step_rem),
      .quo_o  (step_quo)
   );
`endif

   // Sign fix-up of the last step's output; word quotient sits in the low 32 bits
   always_comb begin
      q_fin   = neg_q_q ? -step_quo : step_quo;
      r_fin   = neg_r_q ? -step_rem : step_rem;
      res_fin = is_rem_q ? r_fin : q_fin;
      if (word_q) begin
         res_fin = wext(res_fin);
      end
   end

   // Next-state, datapath updates, busy and valid
   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      acc_d            = acc_q;
      quo_d            = quo_q;
      dvsr_d           = dvsr_q;
      result_d         = result_q;
      is_rem_d         = is_rem_q;
      word_d           = word_q;
      neg_q_d          = neg_q_q;
      neg_r_d          = neg_r_q;
      o_riscv_div_busy  = 1'b0;
      o_riscv_div_valid = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req) begin
               o_riscv_div_busy = 1'b1;
               is_rem_d = is_rem;
               word_d   = i_riscv_div_word;
               neg_q_d  = a_neg ^ b_neg;
               neg_r_d  = a_neg;
               if (div_zero || ovf) begin
                  result_d = spec_res;
                  state_d  = StDone;
               end else begin
                  acc_d   = '0;
                  dvsr_d  = mag_b;
                  // Word dividend is parked at the top so it shifts out first
                  quo_d   = i_riscv_div_word ? {mag_a[31:0], {(width-32){1'b0}}} : mag_a;
                  cnt_d   = i_riscv_div_word ? CntW'(IterWord) : CntW'(IterFull);
                  state_d = StBusy;
               end
            end
         end
         StBusy: begin
            o_riscv_div_busy = 1'b1;
            acc_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
               result_d = res_fin;
               state_d  = StDone;
            end
         end
         StDone: begin
            o_riscv_div_valid = 1'b1;
            cnt_d   = '0;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Flush overrides everything: no accept, no completion, no strobe
      if (i_riscv_div_kill) begin
         state_d           = StIdle;
         cnt_d             = '0;
         acc_d             = acc_q;
         quo_d             = quo_q;
         dvsr_d            = dvsr_q;
         result_d          = result_q;
         is_rem_d          = is_rem_q;
         word_d            = word_q;
         neg_q_d           = neg_q_q;
         neg_r_d           = neg_r_q;
         o_riscv_div_busy  = 1'b0;
         o_riscv_div_valid = 1'b0;
      end
   end

   // State and datapath registers
   always_ff @(posedge i_riscv_div_clk or negedge i_riscv_div_rst) begin
      if (!i_riscv_div_rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         acc_q    <= '0;
         quo_q    <= '0;
         dvsr_q   <= '0;
         result_q <= '0;
         is_rem_q <= 1'b0;
         word_q   <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         quo_q    <= quo_d;
         dvsr_q   <= dvsr_d;
         result_q <= result_d;
         is_rem_q <= is_rem_d;
         word_q   <= word_d;
         neg_q_q  <= neg_q_d;
         neg_r_q  <= neg_r_d;
      end
   end

   assign o_riscv_div_result = result_q;

endmodule
